rtp_rx_depacketizer: RTL and testbench

Receive-side counterpart of the RTP audio packetizer. It consumes the UDP receive byte stream, validates the 12-byte RTP header (version/flags, payload type, SSRC, sequence continuity) and unpacks big-endian 16-bit PCM samples into a jitter FIFO. The WM8731 DAC path pops samples from that FIFO at the codec sample rate. Status counters report accepted and rejected packets, sequence gaps, and FIFO overrun/underrun.

---
 rtl/rtp_rx_depacketizer_pkg.sv | 25 ++
 rtl/rtp_rx_depacketizer_sample_fifo.sv | 51 +++++
 rtl/rtp_rx_depacketizer.sv | 147 ++++++++++++++
 tb/tb_rtp_rx_depacketizer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtp_rx_depacketizer_pkg.sv
// Shared RTP definitions for the packetizer/depacketizer pair: header constants,
// parser state encoding and the last-byte helper used by the receive framer.
package rtp_rx_depacketizer_pkg;

  localparam int          RTP_HDR_LEN      = 12;
  localparam logic [7:0]  RTP_BYTE0        = 8'h80;
  localparam logic [6:0]  RTP_PT           = 7'd0;
  localparam logic [31:0] RTP_DEFAULT_SSRC = 32'h1234_5678;
  // Smallest useful packet: header plus one 16-bit sample.
  localparam int          RTP_MIN_LEN      = RTP_HDR_LEN + 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_DROP
  } rtp_state_e;

  // True when byte index idx is the final byte of a packet of length len.
  // Lengths of 0 or 1 treat byte 0 as the last byte so a bogus length never stalls the framer.
  function automatic logic is_last(input logic [15:0] idx, input logic [15:0] len);
    return ({1'b0, idx} + 17'd1) >= {1'b0, len};
  endfunction

endpackage

// File: rtl/rtp_rx_depacketizer_sample_fifo.sv
// Synchronous 16-bit sample FIFO; level visible the cycle after push, head readable combinationally.
// A push while full is accepted only if a pop happens in the same cycle, otherwise it is flagged as dropped.
module sample_fifo #(
  parameter int  DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [15:0]   push_data,
  input  logic          pop,
  output logic [15:0]   head,
  output logic [LW-1:0] level,
  output logic          empty,
  output logic          dropped
);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    full    = (level == LW'(DEPTH));
    empty   = (level == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dropped = push && full && !do_pop;
    head    = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + {{(LW-1){1'b0}}, do_push} - {{(LW-1){1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/rtp_rx_depacketizer.sv
// RTP receive depacketizer: validates header, unpacks big-endian PCM into a jitter FIFO, serves DAC reads.
// Samples land in the FIFO one cycle after their low byte; reads answer one cycle after wav_rd.
module rtp_rx_depacketizer
  import rtp_rx_depacketizer_pkg::*;
#(
  parameter logic [31:0] SSRC           = RTP_DEFAULT_SSRC,
  parameter int          MAX_UDP_LENGTH = 960,
  parameter int          FIFO_DEPTH     = 1024,
  localparam int         LW             = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          udp_rec_data_valid,
  input  logic [7:0]    udp_rec_rdata,
  input  logic [15:0]   udp_rec_data_length,
  input  logic          wav_rd,
  output logic [15:0]   wav_out_data,
  output logic          wav_out_strobe,
  output logic [15:0]   pkt_ok_cnt,
  output logic [15:0]   pkt_err_cnt,
  output logic [15:0]   seq_gap_cnt,
  output logic [LW-1:0] fifo_level,
  output logic          overrun,
  output logic          underrun
);

  rtp_state_e  state;
  logic [15:0] idx;
  logic [15:0] len_q;
  logic [15:0] seq_q;
  logic [15:0] expected;
  logic [23:0] ssrc_q;
  logic [7:0]  hi_q;
  logic        have_seq;

  logic [15:0] cur_len;
  logic        last;
  logic        len_bad;
  logic        push;
  logic [15:0] head;
  logic        empty;
  logic        dropped;

  // In IDLE the length is not latched yet, so framing decisions use the live input.
  always_comb begin
    cur_len = (state == ST_IDLE) ? udp_rec_data_length : len_q;
    last    = is_last(idx, cur_len);
    len_bad = (udp_rec_data_length < 16'(RTP_MIN_LEN))
           || (32'(udp_rec_data_length) > 32'(MAX_UDP_LENGTH))
           || udp_rec_data_length[0];
    push    = udp_rec_data_valid && (state == ST_PAYLOAD) && idx[0];
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({hi_q, udp_rec_rdata}),
    .pop       (wav_rd),
    .head      (head),
    .level     (fifo_level),
    .empty     (empty),
    .dropped   (dropped)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      idx            <= '0;
      len_q          <= '0;
      seq_q          <= '0;
      expected       <= '0;
      ssrc_q         <= '0;
      hi_q           <= '0;
      have_seq       <= 1'b0;
      pkt_ok_cnt     <= '0;
      pkt_err_cnt    <= '0;
      seq_gap_cnt    <= '0;
      wav_out_data   <= '0;
      wav_out_strobe <= 1'b0;
      overrun        <= 1'b0;
      underrun       <= 1'b0;
    end else begin
      if (udp_rec_data_valid) begin
        idx <= last ? 16'd0 : idx + 16'd1;
        case (state)
          ST_IDLE: begin
            len_q <= udp_rec_data_length;
            if (len_bad || (udp_rec_rdata != RTP_BYTE0)) begin
              if (last) begin
                pkt_err_cnt <= pkt_err_cnt + 16'd1;
              end else begin
                state <= ST_DROP;
              end
            end else begin
              state <= ST_HDR;
            end
          end
          ST_HDR: begin
            case (idx)
              16'd1: if (udp_rec_rdata[6:0] != RTP_PT) state <= ST_DROP;
              16'd2: seq_q[15:8] <= udp_rec_rdata;
              16'd3: seq_q[7:0]  <= udp_rec_rdata;
              16'd8, 16'd9, 16'd10: ssrc_q <= {ssrc_q[15:0], udp_rec_rdata};
              16'(RTP_HDR_LEN - 1): begin
                if ({ssrc_q, udp_rec_rdata} == SSRC) begin
                  state <= ST_PAYLOAD;
                  if (have_seq && (seq_q != expected) && (seq_gap_cnt != 16'hFFFF))
                    seq_gap_cnt <= seq_gap_cnt + 16'd1;
                  have_seq <= 1'b1;
                  expected <= seq_q + 16'd1;
                end else begin
                  state <= ST_DROP;
                end
              end
              default: ;  // timestamp bytes carry no information for playback
            endcase
          end
          ST_PAYLOAD: begin
            if (!idx[0]) hi_q <= udp_rec_rdata;
            if (last) begin
              state      <= ST_IDLE;
              pkt_ok_cnt <= pkt_ok_cnt + 16'd1;
            end
          end
          ST_DROP: begin
            if (last) begin
              state       <= ST_IDLE;
              pkt_err_cnt <= pkt_err_cnt + 16'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end

      wav_out_strobe <= wav_rd;
      if (wav_rd) begin
        wav_out_data <= empty ? 16'h0000 : head;
        if (empty) underrun <= 1'b1;
      end
      if (dropped) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rtp_rx_depacketizer.sv
// Randomized bench for rtp_rx_depacketizer with a packet-level queue model compared every cycle.
`timescale 1ns/1ps
module tb_rtp_rx_depacketizer;
  import rtp_rx_depacketizer_pkg::*;

  localparam int          DEPTH  = 8;
  localparam int          LW     = $clog2(DEPTH) + 1;
  localparam int          MAXLEN = 960;
  localparam logic [31:0] SSRC_T = 32'h1234_5678;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          udp_rec_data_valid = 1'b0;
  logic [7:0]    udp_rec_rdata = 8'h00;
  logic [15:0]   udp_rec_data_length = 16'h0000;
  logic          wav_rd = 1'b0;
  logic [15:0]   wav_out_data;
  logic          wav_out_strobe;
  logic [15:0]   pkt_ok_cnt;
  logic [15:0]   pkt_err_cnt;
  logic [15:0]   seq_gap_cnt;
  logic [LW-1:0] fifo_level;
  logic          overrun;
  logic          underrun;

  rtp_rx_depacketizer #(
    .SSRC           (SSRC_T),
    .MAX_UDP_LENGTH (MAXLEN),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .udp_rec_data_valid  (udp_rec_data_valid),
    .udp_rec_rdata       (udp_rec_rdata),
    .udp_rec_data_length (udp_rec_data_length),
    .wav_rd              (wav_rd),
    .wav_out_data        (wav_out_data),
    .wav_out_strobe      (wav_out_strobe),
    .pkt_ok_cnt          (pkt_ok_cnt),
    .pkt_err_cnt         (pkt_err_cnt),
    .seq_gap_cnt         (seq_gap_cnt),
    .fifo_level          (fifo_level),
    .overrun             (overrun),
    .underrun            (underrun)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;
  bit rd_rand = 1'b0;

  // Per-byte events announced by the driver from its own verdict on the packet.
  bit          ev_push, ev_ok, ev_err, ev_match;
  logic [15:0] ev_sample, ev_seq;

  // Reference model state.
  logic [15:0] mq[$];
  logic [15:0] m_data, m_ok, m_err, m_gap, m_exp;
  bit          m_strobe, m_under, m_over, m_have;

  logic [7:0]  pb[$];
  logic [15:0] ps[$];
  logic [15:0] rseq;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_data = 0; m_ok = 0; m_err = 0; m_gap = 0; m_exp = 0;
      m_strobe = 0; m_under = 0; m_over = 0; m_have = 0;
    end else begin
      m_strobe = wav_rd;
      if (wav_rd) begin
        if (mq.size() > 0) m_data = mq.pop_front();
        else begin m_data = 16'h0000; m_under = 1; end
      end
      if (ev_push) begin
        if (mq.size() < DEPTH) mq.push_back(ev_sample);
        else m_over = 1;
      end
      if (ev_ok)  m_ok++;
      if (ev_err) m_err++;
      if (ev_match) begin
        if (m_have && ev_seq != m_exp && m_gap != 16'hFFFF) m_gap++;
        m_have = 1;
        m_exp  = ev_seq + 16'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("wav_out_data",   32'(wav_out_data),   32'(m_data));
      chk("wav_out_strobe", 32'(wav_out_strobe), 32'(m_strobe));
      chk("pkt_ok_cnt",     32'(pkt_ok_cnt),     32'(m_ok));
      chk("pkt_err_cnt",    32'(pkt_err_cnt),    32'(m_err));
      chk("seq_gap_cnt",    32'(seq_gap_cnt),    32'(m_gap));
      chk("fifo_level",     32'(fifo_level),     32'(mq.size()));
      chk("overrun",        32'(overrun),        32'(m_over));
      chk("underrun",       32'(underrun),       32'(m_under));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    udp_rec_data_valid = 1'b0;
    ev_push = 0; ev_ok = 0; ev_err = 0; ev_match = 0;
    wav_rd = rd_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  task automatic build(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [15:0] seq, input logic [31:0] ssrc);
    pb.delete();
    pb.push_back(b0); pb.push_back(b1); pb.push_back(seq[15:8]); pb.push_back(seq[7:0]);
    for (int k = 0; k < 4; k++) pb.push_back(8'($urandom));
    pb.push_back(ssrc[31:24]); pb.push_back(ssrc[23:16]);
    pb.push_back(ssrc[15:8]);  pb.push_back(ssrc[7:0]);
    foreach (ps[k]) begin pb.push_back(ps[k][15:8]); pb.push_back(ps[k][7:0]); end
  endtask

  task automatic send(input int len, input int nsend, input bit rd_last, input bit gaps);
    bit          acc;
    int          lastidx;
    logic [15:0] seq;
    while (pb.size() < len || pb.size() < nsend) pb.push_back(8'($urandom));
    acc = (len >= 14) && (len <= MAXLEN) && (len % 2 == 0) && (pb[0] == 8'h80)
       && (pb[1][6:0] == 7'd0) && ({pb[8], pb[9], pb[10], pb[11]} == SSRC_T);
    lastidx = (len <= 1) ? 0 : len - 1;
    seq = {pb[2], pb[3]};
    for (int i = 0; i < nsend; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) step();
      udp_rec_data_valid  = 1'b1;
      udp_rec_rdata       = pb[i];
      udp_rec_data_length = 16'(len);
      if (acc) begin
        ev_match = (i == 11);
        ev_seq   = seq;
        if (i >= 13 && i % 2 == 1) begin ev_push = 1; ev_sample = {pb[i-1], pb[i]}; end
        ev_ok = (i == len - 1);
      end else begin
        ev_err = (i == lastidx);
      end
      if (rd_last && i == lastidx) wav_rd = 1'b1;
      step();
    end
  endtask

  task automatic send_full(input int len, input bit rd_last, input bit gaps);
    send(len, (len <= 1) ? 1 : len, rd_last, gaps);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] exp);
    wav_rd = 1'b1;
    step();
    @(negedge clk);
    chk(nm, 32'(wav_out_data), 32'(exp));
    chk("read strobe", 32'(wav_out_strobe), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int          kind, len;
    logic [7:0]  b0, b1;
    logic [31:0] ss;
    logic [15:0] sq;

    step();
    cmp_en = 1'b1;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset ok_cnt", 32'(pkt_ok_cnt), 32'd0);
    chk("reset level", 32'(fifo_level), 32'd0);
    chk("reset data", 32'(wav_out_data), 32'd0);

    // Basic packet and ordered readback.
    ps = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0001};
    build(8'h80, 8'h00, 16'd5, SSRC_T); send_full(20, 0, 0);
    @(negedge clk);
    chk("basic ok_cnt", 32'(pkt_ok_cnt), 32'd1);
    chk("basic level", 32'(fifo_level), 32'd4);
    rd_chk("rd0", 16'h1234); rd_chk("rd1", 16'hFFFF);
    rd_chk("rd2", 16'h8000); rd_chk("rd3", 16'h0001);

    // Sequence continuity: 7,8,10 is one gap; 10 -> FFFF is a second; FFFF -> 0 is continuous.
    do_reset();
    ps = '{16'h0042};
    build(8'h80, 8'h00, 16'd7,  SSRC_T); send_full(14, 0, 0);
    build(8'h80, 8'h80, 16'd8,  SSRC_T); send_full(14, 0, 0);
    build(8'h80, 8'h00, 16'd10, SSRC_T); send_full(14, 0, 0);
    @(negedge clk);
    chk("gap 7-8-10", 32'(seq_gap_cnt), 32'd1);
    build(8'h80, 8'h00, 16'hFFFF, SSRC_T); send_full(14, 0, 0);
    build(8'h80, 8'h00, 16'h0000, SSRC_T); send_full(14, 0, 0);
    @(negedge clk);
    chk("gap wrap", 32'(seq_gap_cnt), 32'd2);

    // Rejections.
    do_reset();
    ps = '{16'h1111};
    build(8'h80, 8'h00, 16'd1, 32'h1234_5679); send_full(14, 0, 0);
    build(8'h90, 8'h00, 16'd2, SSRC_T);        send_full(14, 0, 0);
    build(8'h80, 8'h00, 16'd3, SSRC_T);        send_full(15, 0, 0);
    @(negedge clk);
    chk("err_cnt", 32'(pkt_err_cnt), 32'd3);
    chk("err level", 32'(fifo_level), 32'd0);
    build(8'h80, 8'h00, 16'd4, SSRC_T); send_full(14, 0, 0);
    @(negedge clk);
    chk("ok after err", 32'(pkt_ok_cnt), 32'd1);

    // Underrun.
    do_reset();
    rd_chk("underrun data", 16'h0000);
    chk("underrun flag", 32'(underrun), 32'd1);
    repeat (3) step();
    @(negedge clk);
    chk("underrun sticky", 32'(underrun), 32'd1);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    ps.delete();
    for (int k = 0; k < 8; k++) ps.push_back(16'(k + 1));
    build(8'h80, 8'h00, 16'd20, SSRC_T); send_full(28, 0, 0);
    @(negedge clk);
    chk("full level", 32'(fifo_level), 32'd8);
    ps = '{16'hBEEF};
    build(8'h80, 8'h00, 16'd21, SSRC_T); send_full(14, 1, 0);
    @(negedge clk);
    chk("push+pop level", 32'(fifo_level), 32'd8);
    chk("push+pop overrun", 32'(overrun), 32'd0);
    chk("push+pop data", 32'(wav_out_data), 32'h1);

    // Overrun keeps the oldest samples.
    do_reset();
    ps.delete();
    for (int k = 0; k < 10; k++) ps.push_back(16'(16'h100 + k));
    build(8'h80, 8'h00, 16'd30, SSRC_T); send_full(32, 0, 0);
    @(negedge clk);
    chk("overrun level", 32'(fifo_level), 32'd8);
    chk("overrun flag", 32'(overrun), 32'd1);
    for (int k = 0; k < 8; k++) rd_chk("overrun drain", 16'(16'h100 + k));

    // Reset in the middle of a packet.
    do_reset();
    ps = '{16'h0AAA};
    build(8'h80, 8'h00, 16'd100, SSRC_T); send_full(14, 0, 0);
    ps = '{16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04};
    build(8'h80, 8'h00, 16'd101, SSRC_T); send(20, 14, 0, 0);
    udp_rec_data_valid = 1'b1;
    udp_rec_rdata      = pb[14];
    do_reset();
    @(negedge clk);
    chk("midrst ok_cnt", 32'(pkt_ok_cnt), 32'd0);
    chk("midrst level", 32'(fifo_level), 32'd0);
    ps = '{16'h0C01};
    build(8'h80, 8'h00, 16'd500, SSRC_T); send_full(14, 0, 0);
    @(negedge clk);
    chk("midrst accept", 32'(pkt_ok_cnt), 32'd1);
    chk("midrst no gap", 32'(seq_gap_cnt), 32'd0);

    // Randomized traffic with concurrent reads.
    do_reset();
    rd_rand = 1'b1;
    rseq = 16'($urandom);
    for (int p = 0; p < 80; p++) begin
      kind = $urandom_range(0, 9);
      b0 = 8'h80;
      b1 = {1'($urandom), 7'd0};
      ss = SSRC_T;
      sq = ($urandom_range(0, 4) == 0) ? 16'($urandom) : rseq;
      rseq = sq + 16'd1;
      len = 14 + 2 * $urandom_range(0, 10);
      case (kind)
        0: b0 = 8'h80 ^ (8'h01 << $urandom_range(0, 7));
        1: b1[6:0] = 7'($urandom_range(1, 127));
        2: ss = SSRC_T ^ (32'h1 << $urandom_range(0, 31));
        3: len = $urandom_range(0, 13);
        4: len = 15 + 2 * $urandom_range(0, 10);
        default: ;
      endcase
      ps.delete();
      build(b0, b1, sq, ss);
      send_full(len, 0, 1);
      if ($urandom_range(0, 5) == 0) repeat ($urandom_range(1, 10)) step();
    end
    ps.delete();
    build(8'h80, 8'h00, rseq, SSRC_T); send_full(MAXLEN + 2, 0, 1);
    rd_rand = 1'b0;
    repeat (12) begin wav_rd = 1'b1; step(); end
    step();
    @(negedge clk);
    chk("final level", 32'(fifo_level), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
